// File: rtl/led_pulser.sv
// One-shot LED blinker: each event gives an ON period then a forced-off GAP period.
// Optional event queuing (pending counter) is compiled in with LED_PULSER_QUEUE_EN.
module led_pulser #(
    parameter int CNT_W      = 16,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 50000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_in,
    output logic       led_out,
    output logic       busy,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // The counter is loaded with N-1 so that the state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic             LED_ON   = ~ACTIVE_LOW;
    localparam logic             LED_OFF  = ACTIVE_LOW;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             led_q;
    logic             busy_q;
    logic             gap_last;
    logic             have_pend;

    assign gap_last = (state_q == S_GAP) && (cnt_q == '0);

`ifdef LED_PULSER_QUEUE_EN
    logic [2:0] pend_q;
    logic [2:0] pend_d;

    // On the last GAP cycle a replay consumes one entry unless a fresh event
    // arrives in the same cycle, in which case the two cancel.
    always_comb begin
        pend_d = pend_q;
        if (gap_last) begin
            if ((pend_q != 3'd0) && !evt_in) begin
                pend_d = pend_q - 3'd1;
            end
        end else if ((state_q != S_IDLE) && evt_in && (pend_q != 3'd7)) begin
            pend_d = pend_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 3'd0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign have_pend = (pend_q != 3'd0);
    assign pending   = pend_q;
`else
    assign have_pend = 1'b0;
    assign pending   = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (evt_in) begin
                        state_q <= S_ON;
                        cnt_q   <= ON_LOAD;
                        led_q   <= LED_ON;
                        busy_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        state_q <= S_GAP;
                        cnt_q   <= GAP_LOAD;
                        led_q   <= LED_OFF;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        if (have_pend || evt_in) begin
                            state_q <= S_ON;
                            cnt_q   <= ON_LOAD;
                            led_q   <= LED_ON;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    led_q   <= LED_OFF;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_pulser.sv
// Bench for led_pulser: per-cycle scenario tables feeding a scoreboard queue,
// driving an active-high and an active-low instance from the same stimulus.
module tb_led_pulser;

    localparam int NC = 28;
    localparam int NS = 5;
`ifdef LED_PULSER_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt_in = 1'b0;
    logic       led, led_n, busy, busy_n;
    logic [2:0] pend, pend_n;

    always #5 clk = ~clk;

    led_pulser #(.CNT_W(8), .ON_CYCLES(4), .GAP_CYCLES(3), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .evt_in(evt_in),
        .led_out(led), .busy(busy), .pending(pend)
    );

    led_pulser #(.CNT_W(8), .ON_CYCLES(4), .GAP_CYCLES(3), .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .rst(rst), .evt_in(evt_in),
        .led_out(led_n), .busy(busy_n), .pending(pend_n)
    );

    typedef struct {
        string                 name;
        logic [NC-1:0]         evt;
        logic [NC-1:0]         rst;
        logic [NC-1:0]         led;
        logic [NC-1:0]         busy;
        logic [NC-1:0][2:0]    pend;
    } scen_t;

    typedef struct {
        string      tag;
        int         cyc;
        logic       led;
        logic       busy;
        logic [2:0] pend;
    } exp_t;

    scen_t scen [NS];
    exp_t  sb [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic logic [NC-1:0] rng(input int lo, input int hi);
        logic [NC-1:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] at(input int c);
        return rng(c, c);
    endfunction

    task automatic set_pend(input int s, input int lo, input int hi, input logic [2:0] v);
        for (int i = lo; i <= hi; i++) scen[s].pend[i] = v;
    endtask

    task automatic chk(input string what, input string tag, input int cyc,
                       input logic [2:0] act, input logic [2:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s [%s] cyc %0d: got %0d, expected %0d", what, tag, cyc, act, req);
        end
    endtask

    // Drive one cycle of stimulus; when do_chk is set, queue the expectation for
    // this cycle's outputs and compare it at the falling edge.
    task automatic run_cycle(input string tag, input int c, input logic r, input logic e,
                             input logic x_led, input logic x_busy, input logic [2:0] x_pend,
                             input bit do_chk);
        exp_t x;
        exp_t y;
        @(posedge clk);
        #1;
        rst    = r;
        evt_in = e;
        if (do_chk) begin
            x.tag = tag; x.cyc = c; x.led = x_led; x.busy = x_busy; x.pend = x_pend;
            sb.push_back(x);
        end
        @(negedge clk);
        if (do_chk) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard [%s] cyc %0d: got empty queue, expected an entry", tag, c);
            end else begin
                y = sb.pop_front();
                chk("led_out",    y.tag, y.cyc, {2'b00, led},    {2'b00, y.led});
                chk("busy",       y.tag, y.cyc, {2'b00, busy},   {2'b00, y.busy});
                chk("pending",    y.tag, y.cyc, pend,            y.pend);
                chk("led_out_al", y.tag, y.cyc, {2'b00, led_n},  {2'b00, ~y.led});
                chk("busy_al",    y.tag, y.cyc, {2'b00, busy_n}, {2'b00, y.busy});
                chk("pending_al", y.tag, y.cyc, pend_n,          y.pend);
                $display("[%s] cyc %0d rst=%0b evt=%0b led=%0b busy=%0b pend=%0d led_al=%0b",
                         tag, c, r, e, led, busy, pend, led_n);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin
            scen[s].evt  = '0;
            scen[s].rst  = rng(0, 3);
            scen[s].led  = '0;
            scen[s].busy = '0;
            scen[s].pend = '0;
        end

        scen[0].name = "single";
        scen[0].evt  = at(10);
        scen[0].led  = rng(11, 14);
        scen[0].busy = rng(11, 17);

        scen[1].name = "queue";
        scen[1].evt  = at(10) | at(12);
        if (QEN) begin
            scen[1].led  = rng(11, 14) | rng(18, 21);
            scen[1].busy = rng(11, 24);
            set_pend(1, 13, 17, 3'd1);
        end else begin
            scen[1].led  = rng(11, 14);
            scen[1].busy = rng(11, 17);
        end

        scen[2].name = "saturate";
        scen[2].evt  = rng(10, 19);
        if (QEN) begin
            scen[2].led  = rng(11, 14) | rng(18, 21) | rng(25, 27);
            scen[2].busy = rng(11, 27);
            for (int c = 12; c <= 17; c++) set_pend(2, c, c, 3'(c - 11));
            set_pend(2, 18, 18, 3'd6);
            set_pend(2, 19, 24, 3'd7);
            set_pend(2, 25, 27, 3'd6);
        end else begin
            scen[2].led  = rng(11, 14) | rng(18, 21);
            scen[2].busy = rng(11, 24);
        end

        scen[3].name = "rst_mid";
        scen[3].evt  = at(10) | at(12) | at(14);
        scen[3].rst  = rng(0, 3) | at(12);
        scen[3].led  = rng(11, 12) | rng(15, 18);
        scen[3].busy = rng(11, 12) | rng(15, 21);

        scen[4].name = "gap_edge";
        scen[4].evt  = at(10) | at(17);
        scen[4].led  = rng(11, 14) | rng(18, 21);
        scen[4].busy = rng(11, 24);

        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                run_cycle(scen[s].name, c, scen[s].rst[c], scen[s].evt[c],
                          scen[s].led[c], scen[s].busy[c], scen[s].pend[c], c != 0);
            end
        end

        // Reset and event in the same idle cycle: the event must be lost.
        for (int c = 0; c < 4; c++) run_cycle("rst_evt", c, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, c != 0);
        run_cycle("rst_evt", 4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        for (int c = 5; c < 10; c++) run_cycle("rst_evt", c, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Back-to-back: an event on the first IDLE cycle after a blink starts immediately.
        run_cycle("b2b", 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        for (int c = 1; c <= 7; c++) run_cycle("b2b", c, 1'b0, 1'b0, c <= 4, 1'b1, 3'd0, 1'b1);
        run_cycle("b2b", 8, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        run_cycle("b2b", 9, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
